// File: rtl/fifo_flags_pkg.sv
// Shared definitions for the token/operand FIFO: read-mode constants,
// width helpers and the status-flag bundle with its derivation rule.
package fifo_flags_pkg;

    // Read-port modes selectable through the FWFT parameter.
    localparam int FIFO_MODE_FWFT = 1;
    localparam int FIFO_MODE_REG  = 0;

    // Status flags kept together so they are always computed from one count.
    typedef struct packed {
        logic empty;
        logic full;
        logic aempty;
        logic afull;
    } fifo_status_t;

    // Pointer width; never narrower than one bit, even for DEPTH = 2.
    function automatic int fifo_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width; must be able to hold DEPTH itself.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Single place where the flag thresholds are interpreted.
    function automatic fifo_status_t fifo_status(input int cnt,
                                                 input int depth,
                                                 input int afull_thresh,
                                                 input int aempty_thresh);
        fifo_status_t s;
        s.empty  = (cnt == 0);
        s.full   = (cnt == depth);
        s.aempty = (cnt <= aempty_thresh);
        s.afull  = (cnt >= afull_thresh);
        return s;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer counter. Wraps from DEPTH-1 back to 0 so the FIFO
// depth need not be a power of two. i_clr is a synchronous clear used for
// flush; i_rst has priority.
module fifo_wrap_ptr #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_ptr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_ptr;

    // Advance on request, wrapping at the last valid index.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            if (r_ptr == LAST_IDX) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// synchronous flush and sticky overflow/underflow flags. The read port is
// either first-word-fall-through or registered with one cycle of latency.
// All status outputs are registered from the next-state count, so nothing
// on the output side depends combinationally on the request inputs.
module fifo_flags
    import fifo_flags_pkg::*;
#(
    parameter int  DATA_WIDTH    = 8,
    parameter int  DEPTH         = 4,
    parameter int  AFULL_THRESH  = 3,
    parameter int  AEMPTY_THRESH = 1,
    parameter int  FWFT          = 1,
    localparam int ADDR_W        = fifo_addr_w(DEPTH),
    localparam int CNT_W         = fifo_cnt_w(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    // Reject illegal configurations at elaboration.
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flags: DEPTH must be at least 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("fifo_flags: AFULL_THRESH must lie in 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
        $error("fifo_flags: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end
    if ((FWFT != FIFO_MODE_FWFT) && (FWFT != FIFO_MODE_REG)) begin : g_bad_mode
        $error("fifo_flags: FWFT must be 0 or 1");
    end

    localparam fifo_status_t RST_STATUS =
        fifo_status(0, DEPTH, AFULL_THRESH, AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     w_wr_ptr;
    logic [ADDR_W-1:0]     w_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    fifo_status_t          r_status;
    fifo_status_t          w_status_next;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_rd_do;
    logic                  w_wr_do;
    logic                  r_overflow;
    logic                  r_underflow;

    // A write into a full FIFO is fine when a read frees a slot this cycle.
    assign w_rd_acc = i_rd & ~r_status.empty;
    assign w_wr_acc = i_wr & (~r_status.full | w_rd_acc);

    // Flush swallows any request presented alongside it.
    assign w_rd_do = w_rd_acc & ~i_flush;
    assign w_wr_do = w_wr_acc & ~i_flush;

    fifo_wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_inc (w_wr_do),
        .o_ptr (w_wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_inc (w_rd_do),
        .o_ptr (w_rd_ptr)
    );

    // Next occupancy and the flags it implies.
    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CNT_W'(w_wr_do) - CNT_W'(w_rd_do);
        end
        w_status_next = fifo_status(int'(w_count_next), DEPTH,
                                    AFULL_THRESH, AEMPTY_THRESH);
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_do) begin
            r_mem[w_wr_ptr] <= i_wr_data;
        end
    end

    // Occupancy count and registered status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_status <= RST_STATUS;
        end else begin
            r_count  <= w_count_next;
            r_status <= w_status_next;
        end
    end

    // Sticky error flags; a new error in the clearing cycle is kept. Flush
    // neither sets nor clears them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (!i_flush && i_wr && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (!i_flush && i_rd && r_status.empty) begin
                r_underflow <= 1'b1;
            end else if (i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is always presented; valid simply mirrors non-empty.
        assign o_rd_data  = r_mem[w_rd_ptr];
        assign o_rd_valid = ~r_status.empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_valid;

        // Registered read: one-cycle valid pulse per accepted read, data held.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else if (i_flush) begin
                r_rd_valid <= 1'b0;
            end else if (w_rd_acc) begin
                r_rd_data  <= r_mem[w_rd_ptr];
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end

        assign o_rd_data  = r_rd_data;
        assign o_rd_valid = r_rd_valid;
    end

    assign o_empty        = r_status.empty;
    assign o_full         = r_status.full;
    assign o_almost_empty = r_status.aempty;
    assign o_almost_full  = r_status.afull;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags. Three instances share one request stream:
//   0: DEPTH=4 FWFT  (AF=3, AE=1)
//   1: DEPTH=5 FWFT  (AF=4, AE=2)   non-power-of-2 depth
//   2: DEPTH=4 registered read (AF=3, AE=1)
// Each instance has its own reference model: an ordered list whose element
// 0 is the oldest word, plus sticky flags, updated from the request rules.
module tb_fifo_flags;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       r_wr, r_rd, r_fl, r_clr, r_rst;
    logic [7:0] r_wd;

    logic [7:0] d_data  [3];
    logic       d_valid [3];
    logic       d_empty [3];
    logic       d_full  [3];
    logic       d_ae    [3];
    logic       d_af    [3];
    logic       d_ovf   [3];
    logic       d_unf   [3];
    logic [2:0] d_cnt   [3];

    int n_vec  = 0;
    int n_fail = 0;

    fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) u_d4 (
        .i_clk(clk), .i_rst(r_rst), .i_flush(r_fl), .i_wr(r_wr), .i_wr_data(r_wd),
        .i_rd(r_rd), .i_clr_err(r_clr), .o_rd_data(d_data[0]), .o_rd_valid(d_valid[0]),
        .o_empty(d_empty[0]), .o_full(d_full[0]), .o_almost_empty(d_ae[0]),
        .o_almost_full(d_af[0]), .o_count(d_cnt[0]), .o_overflow(d_ovf[0]),
        .o_underflow(d_unf[0]));

    fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(2), .FWFT(1)) u_d5 (
        .i_clk(clk), .i_rst(r_rst), .i_flush(r_fl), .i_wr(r_wr), .i_wr_data(r_wd),
        .i_rd(r_rd), .i_clr_err(r_clr), .o_rd_data(d_data[1]), .o_rd_valid(d_valid[1]),
        .o_empty(d_empty[1]), .o_full(d_full[1]), .o_almost_empty(d_ae[1]),
        .o_almost_full(d_af[1]), .o_count(d_cnt[1]), .o_overflow(d_ovf[1]),
        .o_underflow(d_unf[1]));

    fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)) u_reg (
        .i_clk(clk), .i_rst(r_rst), .i_flush(r_fl), .i_wr(r_wr), .i_wr_data(r_wd),
        .i_rd(r_rd), .i_clr_err(r_clr), .o_rd_data(d_data[2]), .o_rd_valid(d_valid[2]),
        .o_empty(d_empty[2]), .o_full(d_full[2]), .o_almost_empty(d_ae[2]),
        .o_almost_full(d_af[2]), .o_count(d_cnt[2]), .o_overflow(d_ovf[2]),
        .o_underflow(d_unf[2]));

    function automatic int dep(input int k);
        return (k == 1) ? 5 : 4;
    endfunction
    function automatic int afth(input int k);
        return (k == 1) ? 4 : 3;
    endfunction
    function automatic int aeth(input int k);
        return (k == 1) ? 2 : 1;
    endfunction
    function automatic bit is_fwft(input int k);
        return k != 2;
    endfunction

    logic [7:0] m_q   [3][8];
    int         m_cnt [3];
    bit         m_ovf [3];
    bit         m_unf [3];
    bit         m_rv  [3];
    logic [7:0] m_rd  [3];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, want);
        end
    endtask

    task automatic model_step();
        bit         ra, wa, so, su;
        logic [7:0] head;
        for (int k = 0; k < 3; k++) begin
            if (r_rst) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_rv[k] = 0; m_rd[k] = 8'h00;
            end else if (r_fl) begin
                m_cnt[k] = 0;
                m_rv[k]  = 0;
                if (r_clr) begin
                    m_ovf[k] = 0; m_unf[k] = 0;
                end
            end else begin
                ra   = r_rd && (m_cnt[k] > 0);
                wa   = r_wr && ((m_cnt[k] < dep(k)) || ra);
                so   = r_wr && !wa;
                su   = r_rd && (m_cnt[k] == 0);
                head = m_q[k][0];
                if (ra) begin
                    for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
                    m_cnt[k]--;
                end
                if (wa) begin
                    m_q[k][m_cnt[k]] = r_wd;
                    m_cnt[k]++;
                end
                m_ovf[k] = so || (m_ovf[k] && !r_clr);
                m_unf[k] = su || (m_unf[k] && !r_clr);
                m_rv[k]  = ra;
                if (ra) m_rd[k] = head;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("count",  k, 32'(d_cnt[k]),   32'(m_cnt[k]));
            chk("empty",  k, 32'(d_empty[k]), 32'(m_cnt[k] == 0));
            chk("full",   k, 32'(d_full[k]),  32'(m_cnt[k] == dep(k)));
            chk("aempty", k, 32'(d_ae[k]),    32'(m_cnt[k] <= aeth(k)));
            chk("afull",  k, 32'(d_af[k]),    32'(m_cnt[k] >= afth(k)));
            chk("ovf",    k, 32'(d_ovf[k]),   32'(m_ovf[k]));
            chk("unf",    k, 32'(d_unf[k]),   32'(m_unf[k]));
            if (is_fwft(k)) begin
                chk("valid", k, 32'(d_valid[k]), 32'(m_cnt[k] != 0));
                if (m_cnt[k] != 0) chk("data", k, 32'(d_data[k]), 32'(m_q[k][0]));
            end else begin
                chk("valid", k, 32'(d_valid[k]), 32'(m_rv[k]));
                chk("data",  k, 32'(d_data[k]),  32'(m_rd[k]));
            end
        end
    endtask

    task automatic cyc(input logic wr, input logic [7:0] wd, input logic rd,
                       input logic fl = 1'b0, input logic clr = 1'b0, input logic rst = 1'b0);
        r_wr = wr; r_wd = wd; r_rd = rd; r_fl = fl; r_clr = clr; r_rst = rst;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    logic [7:0] wv [4];
    logic [7:0] dv [4];

    initial begin
        r_wr = 0; r_wd = 0; r_rd = 0; r_fl = 0; r_clr = 0; r_rst = 1;
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 1);
        chk("rst_empty", 0, 32'(d_empty[0]), 1);
        chk("rst_count", 0, 32'(d_cnt[0]), 0);
        chk("rst_aempty", 0, 32'(d_ae[0]), 1);
        chk("rst_rdata", 2, 32'(d_data[2]), 0);
        chk("rst_valid", 2, 32'(d_valid[2]), 0);

        // Fill the depth-4 FIFO.
        wv = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cyc(1, wv[i], 0);
            chk("fill_count", 0, 32'(d_cnt[0]), 32'(i + 1));
            chk("fill_afull", 0, 32'(d_af[0]), 32'(i >= 2));
            chk("fill_full",  0, 32'(d_full[0]), 32'(i == 3));
            chk("fill_head",  0, 32'(d_data[0]), 'h11);
        end
        cyc(1, 8'h55, 0);
        chk("ovf_set", 0, 32'(d_ovf[0]), 1);
        chk("ovf_count", 0, 32'(d_cnt[0]), 4);

        // Write and read together while full.
        cyc(1, 8'h66, 1);
        chk("full_rw_count", 0, 32'(d_cnt[0]), 4);
        chk("full_rw_full", 0, 32'(d_full[0]), 1);
        chk("full_rw_head", 0, 32'(d_data[0]), 'h22);
        dv = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) begin
            chk("drain", 0, 32'(d_data[0]), 32'(dv[i]));
            cyc(0, 8'h00, 1);
        end
        chk("drain_empty", 0, 32'(d_empty[0]), 1);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0, 0, 1);

        // Read and write together while empty.
        cyc(1, 8'hA5, 1);
        chk("empty_rw_count", 0, 32'(d_cnt[0]), 1);
        chk("empty_rw_unf", 0, 32'(d_unf[0]), 1);
        chk("empty_rw_data", 0, 32'(d_data[0]), 'hA5);
        cyc(0, 8'h00, 0, 0, 1);
        chk("clr_unf", 0, 32'(d_unf[0]), 0);

        // Registered read port.
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        cyc(0, 8'h00, 1);
        chk("reg_v1", 2, 32'(d_valid[2]), 1);
        chk("reg_d1", 2, 32'(d_data[2]), 'h01);
        cyc(0, 8'h00, 1);
        chk("reg_v2", 2, 32'(d_valid[2]), 1);
        chk("reg_d2", 2, 32'(d_data[2]), 'h02);
        chk("reg_empty", 2, 32'(d_empty[2]), 1);
        cyc(0, 8'h00, 0);
        chk("reg_v3", 2, 32'(d_valid[2]), 0);
        chk("reg_hold", 2, 32'(d_data[2]), 'h02);

        // Flush with a write, overflow set.
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h70 + i), 0);
        cyc(0, 8'h00, 1);
        chk("pre_flush_count", 0, 32'(d_cnt[0]), 3);
        chk("pre_flush_ovf", 0, 32'(d_ovf[0]), 1);
        cyc(1, 8'h99, 0, 1);
        chk("flush_count", 0, 32'(d_cnt[0]), 0);
        chk("flush_empty", 0, 32'(d_empty[0]), 1);
        chk("flush_ovf", 0, 32'(d_ovf[0]), 1);
        cyc(0, 8'h00, 0);
        chk("flush_wr_dropped", 0, 32'(d_cnt[0]), 0);
        cyc(0, 8'h00, 0, 0, 0, 1);
        chk("rst_ovf", 0, 32'(d_ovf[0]), 0);

        // Randomised traffic against the models.
        for (int n = 0; n < 500; n++) begin
            cyc($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 50,
                $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 127) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
Synchronous single-clock FIFO, the next generation of the calculator's token/operand buffer.
- Adds arbitrary (non-power-of-2) depth, an occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Read port is selectable at elaboration time: first-word-fall-through or registered output.
- Sits between the keypad/UART tokeniser and the RPN evaluator, and in the result path to the display driver.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- DEPTH, 4: number of entries; any integer >= 2, not required to be a power of 2.
- AFULL_THRESH, 3: o_almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 1: o_almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.
- FWFT, 1: 1 = head word visible on o_rd_data without a read; 0 = registered read with one-cycle latency.
- Derived localparams: ADDR_W = max(1, $clog2(DEPTH)); CNT_W = $clog2(DEPTH+1).

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous discard of all contents.
- i_wr  in  1  write request.
- i_wr_data  in  DATA_WIDTH  write data.
- i_rd  in  1  read request (FWFT=1: pop/acknowledge head; FWFT=0: fetch).
- i_clr_err  in  1  clears the sticky error flags.
- o_rd_data  out  DATA_WIDTH  read data.
- o_rd_valid  out  1  o_rd_data holds a valid word.
- o_empty  out  1  count == 0.
- o_full  out  1  count == DEPTH.
- o_almost_empty  out  1  count <= AEMPTY_THRESH.
- o_almost_full  out  1  count >= AFULL_THRESH.
- o_count  out  CNT_W  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: a write was rejected.
- o_underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (i_rst) has priority over everything else. After reset:
  - pointers = 0, o_count = 0, o_empty = 1, o_full = 0.
  - o_almost_empty = 1; o_almost_full = 0.
  - o_overflow = o_underflow = 0, o_rd_valid = 0.
  - o_rd_data = 0 when FWFT=0. When FWFT=1 it shows the memory word at pointer 0 (don't-care while o_rd_valid = 0).
  - Storage array is not reset.
- Accept rules, evaluated each cycle on registered state:
  - rd_acc = i_rd & ~o_empty.
  - wr_acc = i_wr & (~o_full | rd_acc). A write is allowed when full if a read is accepted in the same cycle.
- Simultaneous read and write:
  - Empty: only the write is accepted; the read is rejected and flags underflow. No bypass: the word becomes readable next cycle.
  - Full: both are accepted; count is unchanged.
  - Otherwise: both are accepted; count is unchanged.
- Pointers: wrap to 0 after index DEPTH-1. wr_ptr advances on wr_acc; rd_ptr advances on rd_acc. The write stores i_wr_data at wr_ptr.
- Count: count_next = count + wr_acc - rd_acc.
- All status flags are registered and derived from count_next. They reflect the new state on the cycle after the edge, with no combinational path from inputs.
- Error flags:
  - o_overflow sets on i_wr & ~wr_acc.
  - o_underflow sets on i_rd & o_empty.
  - Both hold until i_clr_err or i_rst.
  - If set and clear conditions coincide in one cycle, set wins.
- Flush (i_flush, lower priority than reset):
  - Pointers, count and flags return to their reset values, except the error flags, which are untouched.
  - Any write or read in the same cycle is ignored and does not set error flags.
  - FWFT=0: o_rd_valid is cleared.
- FWFT=1 read port:
  - o_rd_data = mem[rd_ptr] (registered array, combinational mux); o_rd_valid = ~o_empty.
  - i_rd pops the head; the next word appears the following cycle.
- FWFT=0 read port:
  - On rd_acc, o_rd_data <= mem[rd_ptr] and o_rd_valid <= 1 for exactly the next cycle; otherwise o_rd_valid <= 0.
  - o_rd_data holds its last value when no read is accepted.
  - Back-to-back reads yield one word per cycle.
- Threshold parameters outside their legal range are an elaboration error (generate-time check).

Decomposition:
- Shared package/header (fifo_defs.vh):
  - clog2-based width helpers (ADDR_W, CNT_W formulas).
  - Read-mode constants FIFO_MODE_FWFT = 1, FIFO_MODE_REG = 0.
- One natural sub-module, fifo_wrap_ptr (parameters DEPTH, ADDR_W; ports i_clk, i_rst, i_clr, i_inc, o_ptr):
  - Modulo-DEPTH pointer counter, instantiated twice (write and read).
  - Its i_clr is driven by i_flush.
- Storage, count, flags and the read register live in fifo_flags.

Test Plan:
- DEPTH=4, FWFT=1: write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full at count 3; full at 4; o_rd_data = 0x11 throughout. 5th write of 0x55 -> rejected, o_overflow = 1, count stays 4.
- Full FIFO, i_wr=1 with 0x66 and i_rd=1 in the same cycle -> both accepted, count stays 4, o_full stays 1, head becomes 0x22. Draining yields 0x22,0x33,0x44,0x66.
- Empty FIFO, i_wr=1 with 0xA5 and i_rd=1 -> count 1, o_underflow = 1, o_rd_data = 0xA5 next cycle. Pulse i_clr_err -> o_underflow = 0.
- DEPTH=5 (non-power-of-2): run 12 writes interleaved with reads -> data order preserved across the wrap from pointer 4 to 0; count never exceeds 5.
- FWFT=0: load 0x01,0x02; i_rd on two consecutive cycles -> o_rd_valid high on the next two cycles with 0x01 then 0x02; o_empty = 1 afterwards; o_rd_data holds 0x02.
- With 3 entries and o_overflow set, assert i_flush together with i_wr -> count 0, o_empty = 1, write discarded, o_overflow still 1. Then i_rst -> o_overflow = 0.
